param_shift_chain: RTL and testbench
====================================

Name: param_shift_chain

Overview:
- Parametrised successor to the board-level 3-stage, 8-bit, button-stepped shift register.
- A WIDTH-bit, DEPTH-stage chain advances one step per clean rising edge of an asynchronous step input.
- Adds four modes (shift-in, rotate, drain, hold), per-stage valid tracking with an occupancy count, a selectable tap output, and a synchronous clear.
- Sits between the switch/key inputs and the LED outputs of the board top level. The top level inverts the active-low key before driving step.

Parameters:
- WIDTH, 8: data bits per stage (>=1).
- DEPTH, 3: number of stages (>=2). Stage 0 is the input side; stage DEPTH-1 is the output side.
- SEL_W, $clog2(DEPTH): width of tap_sel (derived; not overridden).
- CNT_W, $clog2(DEPTH+1): width of fill_cnt (derived).

Ports:
- clk  in  1  single clock; all state on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- step  in  1  asynchronous level, active-high; each rising edge requests one advance.
- clr  in  1  synchronous clear, active-high, already synchronous to clk.
- mode  in  2  operation applied on each advance.
- data_in  in  WIDTH  value inserted at stage 0 in shift-in mode.
- tap_sel  in  SEL_W  stage index driven onto tap_out.
- stage0_out  out  WIDTH  stage 0 contents.
- data_out  out  WIDTH  stage DEPTH-1 contents.
- tap_out  out  WIDTH  contents of stage tap_sel.
- out_valid  out  1  valid bit of stage DEPTH-1.
- fill_cnt  out  CNT_W  number of valid stages.
- full  out  1  fill_cnt == DEPTH.
- empty  out  1  fill_cnt == 0.
- adv  out  1  one-cycle advance strobe (debug/LED).

Behaviour:
- Reset (async, rst=1):
  - All stages = 0, all valid bits = 0, fill_cnt = 0, adv = 0.
  - out_valid = 0, empty = 1, full = 0.
  - The two synchroniser flops and the previous-value flop reset to 1, so a step held high through reset release causes no advance; a fresh rise is required.
- Step conditioning:
  - step passes through a 2-flop synchroniser (s1, s2) and a previous-value flop p.
  - adv = s2 & ~p, combinational from registers, high for exactly one cycle per rise.
  - step rising before edge E0 makes adv high between E1 and E2; the stages update at E2.
  - Holding step high produces one advance only. A glitch shorter than one clock may be missed; this is acceptable.
- On the edge where adv=1 and clr=0, with m = mode sampled on that edge:
  - 00 SHIFT: stage[i] <= stage[i-1]; stage[0] <= data_in; valid shifts likewise with valid[0] <= 1. fill_cnt <= fill_cnt + 1 - valid[DEPTH-1].
  - 01 ROTATE: stage[0] <= stage[DEPTH-1]; the others shift as in SHIFT. Valid rotates the same way. fill_cnt is unchanged.
  - 10 DRAIN: shift as in SHIFT, with stage[0] <= 0 and valid[0] <= 0. fill_cnt <= fill_cnt - valid[DEPTH-1].
  - 11 HOLD: no change.
- Other cases:
  - A mode change with no adv has no effect.
  - clr=1 (in any cycle, including one where adv=1): all stages, valid bits and fill_cnt cleared on that edge; the advance is discarded. The edge detector still consumes the rise, so the request is not replayed.
- Outputs:
  - stage0_out, data_out, out_valid, fill_cnt, full and empty reflect registered state: no combinational path from data_in or mode.
  - tap_out = stage[tap_sel], combinational mux on tap_sel. tap_sel >= DEPTH drives all zeros.
- Arithmetic: fill_cnt never exceeds DEPTH and never goes below 0. The update rules guarantee this; no saturation logic is required, but an assertion checks it.
- Reset mid-operation: async clear takes effect immediately and overrides any pending adv.

Decomposition:
- Package shift_chain_pkg:
  - Mode constants MODE_SHIFT=2'b00, MODE_ROTATE=2'b01, MODE_DRAIN=2'b10, MODE_HOLD=2'b11.
  - Helper function for the tap mux default.
- Sub-module step_edge_detect (clk, rst, in, pulse):
  - 2-flop synchroniser plus rising-edge detector, with flops resetting to 1.
  - Reused for the other key inputs on the board.

Test Plan (WIDTH=8, DEPTH=3):
1. Reset, then SHIFT 0x11, 0x22, 0x33 (one step rise each) -> stage0_out=0x33, data_out=0x11, fill_cnt=3, full=1, out_valid=1.
2. SHIFT 0x44 -> stages become 0x44/0x33/0x22, data_out=0x22, fill_cnt stays 3.
3. ROTATE from 0x44/0x33/0x22 -> stages become 0x22/0x44/0x33, fill_cnt=3. A second ROTATE gives 0x33/0x22/0x44.
4. From 0x44/0x33/0x22 (full): DRAIN -> stages 0x00/0x44/0x33, fill_cnt=2, out_valid=1. DRAIN twice more -> fill_cnt=0, empty=1, out_valid=0.
5. Step:
   - step held high for 100 cycles -> exactly one adv pulse, with the stage update on the third edge after the rise.
   - step held high across reset release -> no adv.
   - mode=HOLD with a rise -> no change.
6. Clear, tap and reset:
   - clr asserted in the same cycle as adv on a full chain -> all stages 0, fill_cnt=0, no shift.
   - tap_sel=1 -> tap_out=stage[1]; tap_sel=3 -> tap_out=0x00.
   - rst pulsed mid-chain -> all outputs at reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/param_shift_chain_pkg.sv
// Shared constants and helpers for the parametrised shift chain.
package shift_chain_pkg;

    localparam logic [1:0] MODE_SHIFT  = 2'b00;
    localparam logic [1:0] MODE_ROTATE = 2'b01;
    localparam logic [1:0] MODE_DRAIN  = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    // Tap indices at or beyond the chain length drive zeros rather than aliasing a stage.
    function automatic logic tap_in_range(input int sel, input int depth);
        return (sel >= 0) && (sel < depth);
    endfunction

endpackage

// File: rtl/param_shift_chain_if.sv
// Control and observation bundle between the board top level and the shift chain.
// step is a raw asynchronous level; clr, mode, data_in and tap_sel are synchronous to clk.
// There is no valid/ready handshake: each conditioned step rise is one advance request,
// which is always accepted and never back-pressured.
interface param_shift_chain_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
);
    localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             step;
    logic             clr;
    logic [1:0]       mode;
    logic [WIDTH-1:0] data_in;
    logic [SEL_W-1:0] tap_sel;
    logic [WIDTH-1:0] stage0_out;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] tap_out;
    logic             out_valid;
    logic [CNT_W-1:0] fill_cnt;
    logic             full;
    logic             empty;
    logic             adv;

    modport master (
        output step, clr, mode, data_in, tap_sel,
        input  stage0_out, data_out, tap_out, out_valid, fill_cnt, full, empty, adv
    );

    modport slave (
        input  step, clr, mode, data_in, tap_sel,
        output stage0_out, data_out, tap_out, out_valid, fill_cnt, full, empty, adv
    );

endinterface

// File: rtl/param_shift_chain_step_edge_detect.sv
// Two-flop synchroniser plus rising-edge detector for an asynchronous key level.
// All flops reset to 1 so a level already high at reset release is not seen as a rise.
module step_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic s1;
    logic s2;
    logic p;

    // Synchronise the raw level and remember the previous synchronised value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            p  <= 1'b1;
        end else begin
            s1 <= in;
            s2 <= s1;
            p  <= s2;
        end
    end

    assign pulse = s2 & ~p;

endmodule

// File: rtl/param_shift_chain.sv
// WIDTH-bit, DEPTH-stage chain advanced by a conditioned step key, with shift-in,
// rotate, drain and hold modes, per-stage valid bits, an occupancy count and a tap mux.
module param_shift_chain
    import shift_chain_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input logic               clk,
    input logic               rst,
    param_shift_chain_if.slave bus
);

    localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic             adv;
    logic [WIDTH-1:0] tap;

    step_edge_detect u_step (
        .clk   (clk),
        .rst   (rst),
        .in    (bus.step),
        .pulse (adv)
    );

    // Chain state: clear wins over an advance, which is then dropped, not replayed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            valid_q <= '0;
            cnt_q   <= '0;
        end else if (bus.clr) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            valid_q <= '0;
            cnt_q   <= '0;
        end else if (adv) begin
            case (bus.mode)
                MODE_SHIFT: begin
                    for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                    stage_q[0] <= bus.data_in;
                    valid_q    <= {valid_q[DEPTH-2:0], 1'b1};
                    cnt_q      <= cnt_q + CNT_W'(1) - CNT_W'(valid_q[DEPTH-1]);
                end
                MODE_ROTATE: begin
                    for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                    stage_q[0] <= stage_q[DEPTH-1];
                    valid_q    <= {valid_q[DEPTH-2:0], valid_q[DEPTH-1]};
                end
                MODE_DRAIN: begin
                    for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                    stage_q[0] <= '0;
                    valid_q    <= {valid_q[DEPTH-2:0], 1'b0};
                    cnt_q      <= cnt_q - CNT_W'(valid_q[DEPTH-1]);
                end
                default: ; // hold: chain left untouched
            endcase
        end
    end

    // Tap mux: select a stage by index, zeros when the index is past the chain.
    always_comb begin
        tap = '0;
        if (tap_in_range(int'(bus.tap_sel), DEPTH)) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.tap_sel == SEL_W'(i)) tap = stage_q[i];
            end
        end
    end

    assign bus.stage0_out = stage_q[0];
    assign bus.data_out   = stage_q[DEPTH-1];
    assign bus.tap_out    = tap;
    assign bus.out_valid  = valid_q[DEPTH-1];
    assign bus.fill_cnt   = cnt_q;
    assign bus.full       = (cnt_q == CNT_W'(DEPTH));
    assign bus.empty      = (cnt_q == '0);
    assign bus.adv        = adv;

    // Occupancy must stay within the chain length.
    cnt_in_range: assert property (@(posedge clk) disable iff (rst) cnt_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_param_shift_chain.sv
// Directed bench for param_shift_chain with WIDTH=8, DEPTH=3.
module tb_param_shift_chain;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    param_shift_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    param_shift_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full step: rise, hold through the stage update, release and let the
    // synchroniser settle low so the next rise is clean.
    task automatic do_step(input logic [1:0] m, input logic [7:0] d);
        @(negedge clk);
        bus.mode    = m;
        bus.data_in = d;
        bus.step    = 1'b1;
        repeat (3) @(negedge clk);
        bus.step = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_stages(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                                input logic [7:0] s2, input int cnt);
        bus.tap_sel = 2'd1;
        #1;
        check({tag, "_s0"},  32'(bus.stage0_out), 32'(s0));
        check({tag, "_s1"},  32'(bus.tap_out),    32'(s1));
        check({tag, "_s2"},  32'(bus.data_out),   32'(s2));
        check({tag, "_cnt"}, 32'(bus.fill_cnt),   32'(cnt));
    endtask

    initial begin
        int adv_cnt;
        int first_adv;
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.step    = 1'b0;
        bus.clr     = 1'b0;
        bus.mode    = 2'b00;
        bus.data_in = '0;
        bus.tap_sel = '0;
        repeat (3) @(negedge clk);
        check("rst_s0",    32'(bus.stage0_out), 32'h0);
        check("rst_dout",  32'(bus.data_out),   32'h0);
        check("rst_cnt",   32'(bus.fill_cnt),   32'h0);
        check("rst_empty", 32'(bus.empty),      32'h1);
        check("rst_full",  32'(bus.full),       32'h0);
        check("rst_ovld",  32'(bus.out_valid),  32'h0);
        check("rst_adv",   32'(bus.adv),        32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_cnt", 32'(bus.fill_cnt), 32'h0);

        // 1. fill with three shifts
        do_step(2'b00, 8'h11);
        do_step(2'b00, 8'h22);
        do_step(2'b00, 8'h33);
        check_stages("fill", 8'h33, 8'h22, 8'h11, 3);
        check("fill_full", 32'(bus.full),      32'h1);
        check("fill_ovld", 32'(bus.out_valid), 32'h1);

        // 2. shift into a full chain keeps count at DEPTH
        do_step(2'b00, 8'h44);
        check_stages("shift_full", 8'h44, 8'h33, 8'h22, 3);

        // 3. rotate, data_in must be ignored
        do_step(2'b01, 8'hEE);
        check_stages("rot1", 8'h22, 8'h44, 8'h33, 3);
        do_step(2'b01, 8'hEE);
        check_stages("rot2", 8'h33, 8'h22, 8'h44, 3);
        do_step(2'b01, 8'hEE);
        check_stages("rot3", 8'h44, 8'h33, 8'h22, 3);

        // 4. drain out
        do_step(2'b10, 8'hEE);
        check_stages("drain1", 8'h00, 8'h44, 8'h33, 2);
        check("drain1_ovld", 32'(bus.out_valid), 32'h1);
        do_step(2'b10, 8'hEE);
        check_stages("drain2", 8'h00, 8'h00, 8'h44, 1);
        do_step(2'b10, 8'hEE);
        check_stages("drain3", 8'h00, 8'h00, 8'h00, 0);
        check("drain3_empty", 32'(bus.empty),     32'h1);
        check("drain3_ovld",  32'(bus.out_valid), 32'h0);

        // 5a. step held high for 100 cycles: one advance, update on third edge
        @(negedge clk);
        bus.mode    = 2'b00;
        bus.data_in = 8'h5A;
        bus.step    = 1'b1;
        adv_cnt     = 0;
        first_adv   = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (bus.adv) begin
                adv_cnt++;
                if (first_adv < 0) first_adv = i;
            end
            if (i == 2) check("held_before", 32'(bus.stage0_out), 32'h00);
            if (i == 3) check("held_after",  32'(bus.stage0_out), 32'h5A);
        end
        check("held_adv_cnt",   32'(adv_cnt),      32'd1);
        check("held_adv_cycle", 32'(first_adv),    32'd2);
        check("held_cnt",       32'(bus.fill_cnt), 32'd1);
        bus.step = 1'b0;
        repeat (3) @(negedge clk);

        // 5b. step high across reset release: no advance
        bus.step = 1'b1;
        rst      = 1'b1;
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        adv_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.adv) adv_cnt++;
        end
        check("rstheld_adv", 32'(adv_cnt),        32'd0);
        check("rstheld_s0",  32'(bus.stage0_out), 32'h00);
        bus.step = 1'b0;
        repeat (3) @(negedge clk);

        // 5c. hold mode
        do_step(2'b00, 8'h66);
        do_step(2'b11, 8'h77);
        check_stages("hold", 8'h66, 8'h00, 8'h00, 1);

        // 6a. clear coincident with an advance on a full chain
        do_step(2'b00, 8'h01);
        do_step(2'b00, 8'h02);
        check("pre_clr_full", 32'(bus.full), 32'h1);
        @(negedge clk);
        bus.mode    = 2'b00;
        bus.data_in = 8'h99;
        bus.step    = 1'b1;
        repeat (2) @(negedge clk);
        check("clr_adv_seen", 32'(bus.adv), 32'h1);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        check_stages("clr", 8'h00, 8'h00, 8'h00, 0);
        check("clr_empty", 32'(bus.empty), 32'h1);
        repeat (5) @(negedge clk);
        check("clr_noreplay", 32'(bus.stage0_out), 32'h00);
        bus.step = 1'b0;
        repeat (3) @(negedge clk);

        // 6b. tap mux, including an out-of-range index
        do_step(2'b00, 8'hA1);
        do_step(2'b00, 8'hB2);
        bus.tap_sel = 2'd0;
        #1 check("tap0", 32'(bus.tap_out), 32'hB2);
        bus.tap_sel = 2'd1;
        #1 check("tap1", 32'(bus.tap_out), 32'hA1);
        bus.tap_sel = 2'd3;
        #1 check("tap3", 32'(bus.tap_out), 32'h00);

        // 6c. asynchronous reset mid-chain, observed before the next clock edge
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_s0",    32'(bus.stage0_out), 32'h00);
        check("arst_cnt",   32'(bus.fill_cnt),   32'h0);
        check("arst_empty", 32'(bus.empty),      32'h1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
